// File: rtl/jpeg_enc_pkg.sv
// Shared types and constants for the JPEG encoder block controller.
package jpeg_enc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    DCT,
    CAP,
    QUANT,
    HSTART,
    HWAIT,
    DONE
  } seq_state_t;

  localparam int JPEG_BLK_ROWS    = 8;
  localparam int JPEG_MCU420_BLKS = 6;
  localparam int JPEG_MCU420_LUMA = 4;

  // 4:2:0 MCU order is Y,Y,Y,Y,Cb,Cr
  function automatic logic mcu420_is_luma(input logic [2:0] idx);
    return (idx < 3'(JPEG_MCU420_LUMA));
  endfunction

endpackage

// File: rtl/jpeg_seq_row_timer.sv
// Row counter plus per-row cycle counter; a one-row pass doubles as a plain hold timer.
module jpeg_seq_row_timer #(
  parameter int CYC_W = 4,
  parameter int ROW_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             run,
  input  logic [CYC_W-1:0] cyc_len,
  input  logic [ROW_W-1:0] row_len,
  output logic [ROW_W-1:0] row,
  output logic             last_cycle,
  output logic             last_row
);

  localparam logic [CYC_W-1:0] CYC_ONE = 1;
  localparam logic [ROW_W-1:0] ROW_ONE = 1;

  logic [CYC_W-1:0] cyc_reg;
  logic [ROW_W-1:0] row_reg;

  assign row        = row_reg;
  assign last_cycle = (cyc_reg == cyc_len - CYC_ONE);
  assign last_row   = last_cycle && (row_reg == row_len - ROW_ONE);

  // Both counters return to zero after the final cycle of the final row
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cyc_reg <= '0;
      row_reg <= '0;
    end else if (clear) begin
      cyc_reg <= '0;
      row_reg <= '0;
    end else if (run) begin
      if (last_cycle) begin
        cyc_reg <= '0;
        row_reg <= last_row ? '0 : row_reg + ROW_ONE;
      end else begin
        cyc_reg <= cyc_reg + CYC_ONE;
      end
    end
  end

endmodule

// File: rtl/jpeg_block_sequencer.sv
// Per-block control sequencer for the JPEG encoder datapath.
// Optional JPEG_SEQ_SUBSAMPLE_420_EN: component type follows a 4:2:0 MCU block index.
module jpeg_block_sequencer
  import jpeg_enc_pkg::*;
#(
  parameter int DCT_LAT   = 2,
  parameter int QUANT_LAT = 1,
  parameter int ROWS      = JPEG_BLK_ROWS
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       blk_valid,
  output logic       blk_ready,
  input  logic       cfg_is_luminance,
  input  logic       abort,
  input  logic       huff_done,
  output logic       input_enable,
  output logic       dct_enable,
  output logic       dct_input_enable,
  output logic       zigzag_input_enable,
  output logic [7:0] matrix_row,
  output logic       is_luminance,
  output logic       huff_start,
  output logic       blk_done
);

  localparam logic [3:0] DCT_LEN   = 4'(DCT_LAT);
  localparam logic [3:0] QUANT_LEN = 4'(QUANT_LAT);
  localparam logic [7:0] ROW_LEN   = 8'(ROWS);

  seq_state_t state_reg, state_next;
  logic       is_lum_reg;
  logic       accept;
  logic       tmr_run, tmr_clear, tmr_last_cycle, tmr_last_row;
  logic [3:0] tmr_cyc_len;
  logic [7:0] tmr_row_len, tmr_row;

  assign accept = (state_reg == IDLE) && blk_valid && !abort;

  // One timer serves both the DCT hold (single row) and the quantize row walk
  assign tmr_run     = (state_reg == DCT) || (state_reg == QUANT);
  assign tmr_clear   = abort || !tmr_run;
  assign tmr_cyc_len = (state_reg == DCT) ? DCT_LEN : QUANT_LEN;
  assign tmr_row_len = (state_reg == DCT) ? 8'd1 : ROW_LEN;

  jpeg_seq_row_timer #(
    .CYC_W (4),
    .ROW_W (8)
  ) u_row_timer (
    .clock      (clock),
    .reset      (reset),
    .clear      (tmr_clear),
    .run        (tmr_run),
    .cyc_len    (tmr_cyc_len),
    .row_len    (tmr_row_len),
    .row        (tmr_row),
    .last_cycle (tmr_last_cycle),
    .last_row   (tmr_last_row)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (abort) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE:    if (blk_valid) state_next = LOAD;
        LOAD:    state_next = DCT;
        DCT:     if (tmr_last_row) state_next = CAP;
        CAP:     state_next = QUANT;
        QUANT:   if (tmr_last_row) state_next = HSTART;
        HSTART:  state_next = HWAIT;
        HWAIT:   if (huff_done) state_next = DONE;
        DONE:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    blk_ready           = (state_reg == IDLE);
    input_enable        = (state_reg == LOAD);
    dct_enable          = (state_reg == DCT);
    dct_input_enable    = (state_reg == CAP);
    zigzag_input_enable = (state_reg == QUANT) && tmr_last_cycle;
    matrix_row          = (state_reg == QUANT) ? tmr_row : 8'd0;
    huff_start          = (state_reg == HSTART);
    blk_done            = (state_reg == DONE);
    is_luminance        = is_lum_reg;
  end

`ifdef JPEG_SEQ_SUBSAMPLE_420_EN
  logic [2:0] blk_idx_reg;
  logic       unused_cfg_is_luminance;

  assign unused_cfg_is_luminance = cfg_is_luminance;

  // Counts completed blocks; aborted blocks do not advance the MCU position
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      blk_idx_reg <= 3'd0;
    end else if (state_reg == DONE) begin
      blk_idx_reg <= (blk_idx_reg == 3'(JPEG_MCU420_BLKS - 1)) ? 3'd0 : blk_idx_reg + 3'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      is_lum_reg <= 1'b0;
    end else if (accept) begin
      is_lum_reg <= mcu420_is_luma(blk_idx_reg);
    end
  end
`else
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      is_lum_reg <= 1'b0;
    end else if (accept) begin
      is_lum_reg <= cfg_is_luminance;
    end
  end
`endif

endmodule
